// File: rtl/sobel_frame_sequencer.sv
// Frame sequencer: walks every 3x3 window of a frame from the window memory
// through the Sobel engine and writes each result back to memory.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; win_count holds the last frame's value
// MRD   | memory read strobe for the next window
// MWAIT | memory read latency; window captured on the last cycle
// EWR   | engine write strobe carrying the captured window
// EWAIT | engine compute wait
// ERD   | engine read strobe
// ECAP  | engine result captured at the end of this cycle
// MWR   | memory write strobe carrying the result; count advances
// DONE  | one-cycle completion pulse
module sobel_frame_sequencer #(
    parameter int IMG_W   = 64,
    parameter int IMG_H   = 64,
    parameter int RD_LAT  = 2,
    parameter int ENG_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  win_count,
    output logic              mem_data_strobe,
    output logic              mem_bus_rw,
    input  logic [71:0]       mem_bus_out,
    output logic [7:0]        mem_bus_in,
    output logic              data_strobe,
    output logic              bus_rw,
    output logic [71:0]       bus_in,
    input  logic [7:0]        bus_out
);

    localparam logic [CNT_W-1:0] NUM_WIN = CNT_W'((IMG_W - 2) * (IMG_H - 2));
    localparam int MAX_LAT = (RD_LAT > ENG_LAT) ? RD_LAT : ENG_LAT;
    localparam int WAIT_W  = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [WAIT_W-1:0] RD_RELOAD  = WAIT_W'(RD_LAT - 1);
    localparam logic [WAIT_W-1:0] ENG_RELOAD = WAIT_W'((ENG_LAT > 0) ? (ENG_LAT - 1) : 0);

    typedef enum logic [3:0] {
        IDLE, MRD, MWAIT, EWR, EWAIT, ERD, ECAP, MWR, DONE
    } state_t;

    state_t             state_q;
    logic [WAIT_W-1:0]  wait_q;
    logic [71:0]        window_q;
    logic [7:0]         result_q;
    logic [CNT_W-1:0]   win_count_q;
    logic [CNT_W-1:0]   win_count_d;
    logic               busy_q;
    logic               done_q;
    logic               mem_stb_q;
    logic               mem_rw_q;
    logic               eng_stb_q;
    logic               eng_rw_q;

    assign win_count_d = win_count_q + 1'b1;

    // Wait states use a down-counter loaded with LAT-1 and leave on zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            window_q    <= '0;
            result_q    <= '0;
            win_count_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_stb_q   <= 1'b0;
            mem_rw_q    <= 1'b1;
            eng_stb_q   <= 1'b0;
            eng_rw_q    <= 1'b1;
        end else begin
            mem_stb_q <= 1'b0;
            mem_rw_q  <= 1'b1;
            eng_stb_q <= 1'b0;
            eng_rw_q  <= 1'b1;
            done_q    <= 1'b0;
            if (abort && (state_q != IDLE)) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            state_q     <= MRD;
                            win_count_q <= '0;
                            busy_q      <= 1'b1;
                            mem_stb_q   <= 1'b1;
                        end
                    end
                    MRD: begin
                        state_q <= MWAIT;
                        wait_q  <= RD_RELOAD;
                    end
                    MWAIT: begin
                        if (wait_q == '0) begin
                            window_q  <= mem_bus_out;
                            state_q   <= EWR;
                            eng_stb_q <= 1'b1;
                            eng_rw_q  <= 1'b0;
                        end else begin
                            wait_q <= wait_q - 1'b1;
                        end
                    end
                    EWR: begin
                        if (ENG_LAT == 0) begin
                            state_q   <= ERD;
                            eng_stb_q <= 1'b1;
                        end else begin
                            state_q <= EWAIT;
                            wait_q  <= ENG_RELOAD;
                        end
                    end
                    EWAIT: begin
                        if (wait_q == '0) begin
                            state_q   <= ERD;
                            eng_stb_q <= 1'b1;
                        end else begin
                            wait_q <= wait_q - 1'b1;
                        end
                    end
                    ERD: begin
                        state_q <= ECAP;
                    end
                    ECAP: begin
                        result_q  <= bus_out;
                        state_q   <= MWR;
                        mem_stb_q <= 1'b1;
                        mem_rw_q  <= 1'b0;
                    end
                    MWR: begin
                        win_count_q <= win_count_d;
                        if (win_count_d == NUM_WIN) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= MRD;
                            mem_stb_q <= 1'b1;
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign win_count       = win_count_q;
    assign mem_data_strobe = mem_stb_q;
    assign mem_bus_rw      = mem_rw_q;
    assign mem_bus_in      = result_q;
    assign data_strobe     = eng_stb_q;
    assign bus_rw          = eng_rw_q;
    assign bus_in          = window_q;

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Bench for sobel_frame_sequencer: two 4x4 instances (RD_LAT/ENG_LAT 2/3 and 1/0)
// checked every cycle against a timeline model derived from frame offsets.
module tb_sobel_frame_sequencer;

    localparam int NI   = 2;
    localparam int NUMW = 4;
    localparam int CW   = 16;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic abort;

    logic          busy_s [NI];
    logic          done_s [NI];
    logic [CW-1:0] wc_s   [NI];
    logic          mstb_s [NI];
    logic          mrw_s  [NI];
    logic [71:0]   mout_s [NI];
    logic [7:0]    min_s  [NI];
    logic          dstb_s [NI];
    logic          drw_s  [NI];
    logic [71:0]   bin_s  [NI];
    logic [7:0]    bout_s [NI];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit directed = 1'b0;

    // model state per instance
    bit          run  [NI];
    int          base [NI];
    int          wch  [NI];
    int          fid  [NI];
    bit          dirf [NI];
    int unsigned seed [NI];
    logic [71:0] exp_bin [NI];
    logic [7:0]  exp_min [NI];

    // memory / engine responder state
    int          mfid [NI];
    int          rcnt [NI];
    int          mdue [NI];
    logic [71:0] mdat [NI];
    int          edue [NI];
    logic [7:0]  eres [NI];
    logic [71:0] elat [NI];

    logic [7:0] lit_wr [4];

    sobel_frame_sequencer #(.IMG_W(4), .IMG_H(4), .RD_LAT(2), .ENG_LAT(3), .CNT_W(CW)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .busy(busy_s[0]), .done(done_s[0]), .win_count(wc_s[0]),
        .mem_data_strobe(mstb_s[0]), .mem_bus_rw(mrw_s[0]), .mem_bus_out(mout_s[0]), .mem_bus_in(min_s[0]),
        .data_strobe(dstb_s[0]), .bus_rw(drw_s[0]), .bus_in(bin_s[0]), .bus_out(bout_s[0])
    );

    sobel_frame_sequencer #(.IMG_W(4), .IMG_H(4), .RD_LAT(1), .ENG_LAT(0), .CNT_W(CW)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .busy(busy_s[1]), .done(done_s[1]), .win_count(wc_s[1]),
        .mem_data_strobe(mstb_s[1]), .mem_bus_rw(mrw_s[1]), .mem_bus_out(mout_s[1]), .mem_bus_in(min_s[1]),
        .data_strobe(dstb_s[1]), .bus_rw(drw_s[1]), .bus_in(bin_s[1]), .bus_out(bout_s[1])
    );

    always #5 clk = ~clk;

    function automatic int rd_of(int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic int en_of(int i);
        return (i == 0) ? 3 : 0;
    endfunction

    function automatic int per_of(int i);
        return rd_of(i) + en_of(i) + 5;
    endfunction

    function automatic int last_of(int i);
        return NUMW * per_of(i) + 1;
    endfunction

    function automatic int done_lit(int i);
        return (i == 0) ? 41 : 25;
    endfunction

    function automatic logic [71:0] win_fn(bit dir, int unsigned sd, int k);
        logic [7:0] kb;
        kb = 8'(k);
        if (dir) return {9{kb}};
        return {sd ^ (32'(k) * 32'h9E3779B9), sd + (32'(k) * 32'h85EBCA6B), 8'(sd >> k)};
    endfunction

    task automatic chk(input string nm, input int i, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] cyc %0d: got %0h, want %0h", nm, i, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame model: which frame is running and where it started.
    always @(posedge clk) begin
        int po;
        cyc = cyc + 1;
        for (int i = 0; i < NI; i++) begin
            if (!reset) begin
                run[i] = 1'b0;
                wch[i] = 0;
            end else begin
                po = cyc - 1 - base[i];
                if (run[i] && po >= 1 && po <= last_of(i)) begin
                    if (abort) begin
                        run[i] = 1'b0;
                        wch[i] = (po - 1) / per_of(i);
                    end
                end else begin
                    if (run[i]) begin
                        run[i] = 1'b0;
                        wch[i] = NUMW;
                    end
                    if (start) begin
                        run[i]  = 1'b1;
                        base[i] = cyc - 1;
                        wch[i]  = 0;
                        fid[i]  = fid[i] + 1;
                        dirf[i] = directed;
                        seed[i] = $urandom;
                    end
                end
            end
        end
    end

    // Memory and engine responders: observe strobes.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (reset && mstb_s[i] && mrw_s[i]) begin
                if (mfid[i] != fid[i]) begin
                    mfid[i] = fid[i];
                    rcnt[i] = 0;
                end
                mdue[i] = cyc + rd_of(i);
                mdat[i] = win_fn(dirf[i], seed[i], rcnt[i]);
                rcnt[i] = rcnt[i] + 1;
            end
            if (reset && dstb_s[i]) begin
                if (!drw_s[i]) begin
                    elat[i] = bin_s[i];
                end else begin
                    edue[i] = cyc + 1;
                    eres[i] = elat[i][7:0] ^ 8'hA5;
                end
            end
        end
    end

    // Data is valid only in the exact cycle it is due; garbage otherwise.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NI; i++) begin
            mout_s[i] = (cyc == mdue[i]) ? mdat[i] : {$urandom, $urandom, 8'($urandom)};
            bout_s[i] = (cyc == edue[i]) ? eres[i] : 8'($urandom);
        end
    end

    always @(negedge clk) begin
        int o, k, r, rd, en;
        logic e_busy, e_done, e_mstb, e_mrw, e_dstb, e_drw;
        int e_wc;
        for (int i = 0; i < NI; i++) begin
            rd = rd_of(i);
            en = en_of(i);
            e_busy = 1'b0; e_done = 1'b0; e_mstb = 1'b0; e_mrw = 1'b1;
            e_dstb = 1'b0; e_drw = 1'b1; e_wc = 0;
            o = cyc - base[i];
            k = 0;
            if (!reset) begin
                exp_bin[i] = '0;
                exp_min[i] = '0;
            end else if (run[i] && o >= 1 && o <= last_of(i)) begin
                if (o == last_of(i)) begin
                    e_done = 1'b1;
                    e_wc   = NUMW;
                end else begin
                    k = (o - 1) / per_of(i);
                    r = (o - 1) % per_of(i);
                    e_busy = 1'b1;
                    e_wc   = k;
                    if (r == 0) begin
                        e_mstb = 1'b1;
                    end else if (r == rd + 1) begin
                        e_dstb = 1'b1;
                        e_drw  = 1'b0;
                        exp_bin[i] = win_fn(dirf[i], seed[i], k);
                    end else if (r == rd + en + 2) begin
                        e_dstb = 1'b1;
                    end else if (r == rd + en + 4) begin
                        e_mstb = 1'b1;
                        e_mrw  = 1'b0;
                        exp_min[i] = win_fn(dirf[i], seed[i], k) ^ 8'hA5;
                    end
                end
            end else if (run[i]) begin
                e_wc = NUMW;
            end else begin
                e_wc = wch[i];
            end
            chk("busy", i, 72'(busy_s[i]), 72'(e_busy));
            chk("done", i, 72'(done_s[i]), 72'(e_done));
            chk("win_count", i, 72'(wc_s[i]), 72'(e_wc));
            chk("mem_strobe", i, 72'(mstb_s[i]), 72'(e_mstb));
            chk("mem_rw", i, 72'(mrw_s[i]), 72'(e_mrw));
            chk("eng_strobe", i, 72'(dstb_s[i]), 72'(e_dstb));
            chk("eng_rw", i, 72'(drw_s[i]), 72'(e_drw));
            chk("bus_in", i, bin_s[i], exp_bin[i]);
            chk("mem_bus_in", i, 72'(min_s[i]), 72'(exp_min[i]));
            if (reset && run[i] && dirf[i]) begin
                if (mstb_s[i] && !mrw_s[i] && o >= 1 && o < last_of(i))
                    chk("lit_wr_data", i, 72'(min_s[i]), 72'(lit_wr[((o - 1) / per_of(i)) % 4]));
                if (done_s[i]) begin
                    chk("lit_done_cycle", i, 72'(o), 72'(done_lit(i)));
                    chk("lit_done_count", i, 72'(wc_s[i]), 72'(4));
                end
            end
        end
    end

    initial begin
        int n;
        lit_wr[0] = 8'hA5; lit_wr[1] = 8'hA4; lit_wr[2] = 8'hA7; lit_wr[3] = 8'hA6;
        for (int i = 0; i < NI; i++) begin
            run[i] = 1'b0; base[i] = 0; wch[i] = 0; fid[i] = 0; dirf[i] = 1'b0; seed[i] = 0;
            exp_bin[i] = '0; exp_min[i] = '0;
            mfid[i] = -1; rcnt[i] = 0; mdue[i] = -1; edue[i] = -1;
            mdat[i] = '0; eres[i] = '0; elat[i] = '0;
            mout_s[i] = '0; bout_s[i] = '0;
        end
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();

        // directed frame: window k = {9{k}}
        directed = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; directed = 1'b0;
        repeat (45) tick();

        repeat (3) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            repeat (42 + $urandom_range(0, 4)) tick();
        end

        // abort during EWAIT of window 2 (instance 0, cycle offset 16)
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (15) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (45) tick();

        // start held high across frames
        start = 1'b1;
        repeat (50) tick();
        start = 1'b0;
        repeat (50) tick();

        // async reset mid-MWAIT, then a clean frame
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #1 reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (45) tick();

        // start and abort together in IDLE
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        repeat (45) tick();

        repeat (6) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            n = $urandom_range(1, 50);
            repeat (n) tick();
            if ($urandom_range(0, 1) == 1) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
            end
            repeat (45) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
